// File: rtl/agc_pkg.sv
// Shared types and default constants for the automatic gain control loop.
package agc_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MEASURE = 3'd1,
      ADJUST  = 3'd2,
      SETTLE  = 3'd3,
      FLUSH   = 3'd4,
      LOCKED  = 3'd5
   } agc_state_t;

   localparam int DEF_COARSE_STEP   = 4;
   localparam int DEF_SETTLE_CYCLES = 256;
   localparam int DEF_LOCK_COUNT    = 4;

endpackage

// File: rtl/agc_gain_stepper.sv
// Saturating gain step: adds or subtracts a step and clamps to the legal range.
module agc_gain_stepper #(
   parameter int GAIN_WIDTH = 6,
   parameter int GAIN_MIN   = 0,
   parameter int GAIN_MAX   = 63
) (
   input  logic [GAIN_WIDTH-1:0] gain,
   input  logic [GAIN_WIDTH-1:0] step,
   input  logic                  up,
   output logic [GAIN_WIDTH-1:0] gain_next,
   output logic                  at_rail
);
   // Two guard bits so gain_max + step cannot wrap before the clamp.
   localparam int SW = GAIN_WIDTH + 2;
   localparam logic signed [SW-1:0] MAX_S = SW'(GAIN_MAX);
   localparam logic signed [SW-1:0] MIN_S = SW'(GAIN_MIN);

   logic signed [SW-1:0] gain_s;
   logic signed [SW-1:0] step_s;
   logic signed [SW-1:0] sum;

   always_comb begin
      gain_s = $signed({2'b00, gain});
      step_s = $signed({2'b00, step});
      sum    = up ? (gain_s + step_s) : (gain_s - step_s);
      if (sum > MAX_S) begin
         gain_next = GAIN_WIDTH'(GAIN_MAX);
      end else if (sum < MIN_S) begin
         gain_next = GAIN_WIDTH'(GAIN_MIN);
      end else begin
         gain_next = sum[GAIN_WIDTH-1:0];
      end
      at_rail = (gain_next == gain);
   end

endmodule

// File: rtl/agc_gain_controller.sv
// Closed-loop AGC: steps the front-end gain code from detector power reports
// against a programmable window, settles after each step and declares lock.
//
// state   | meaning
// IDLE    | loop disabled, gain held
// MEASURE | waiting for a report, counting consecutive in-window reports
// ADJUST  | one cycle: apply the captured step, saturated to the rails
// SETTLE  | timer running after a gain change, reports ignored
// FLUSH   | discard the first (stale) report after settling
// LOCKED  | lock declared; any out-of-window report re-enters ADJUST
module agc_gain_controller
   import agc_pkg::*;
#(
   parameter int POWER_WIDTH   = 32,
   parameter int GAIN_WIDTH    = 6,
   parameter int GAIN_INIT     = 32,
   parameter int GAIN_MIN      = 0,
   parameter int GAIN_MAX      = 63,
   parameter int COARSE_STEP   = DEF_COARSE_STEP,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int LOCK_COUNT    = DEF_LOCK_COUNT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [POWER_WIDTH-1:0] thr_high,
   input  logic [POWER_WIDTH-1:0] thr_low,
   input  logic [POWER_WIDTH-1:0] avg_power_in,
   input  logic                   avg_power_valid_in,
   output logic [GAIN_WIDTH-1:0]  gain_out,
   output logic                   gain_update,
   output logic                   locked,
   output logic                   gain_saturated,
   output logic                   cfg_err,
   output logic [2:0]             state_out
);
   localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_COUNT - 1);

   agc_state_t            state, state_nxt;
   logic [GAIN_WIDTH-1:0] gain, gain_nxt, gain_stepped, step;
   logic [TW-1:0]         timer, timer_nxt;
   logic [CW-1:0]         win_cnt, win_cnt_nxt;
   logic                  locked_q, locked_nxt;
   logic                  sat_q, sat_nxt;
   logic                  upd_q, upd_nxt;
   logic                  cfg_q;
   logic                  adj_up, adj_up_nxt, adj_coarse, adj_coarse_nxt;
   logic                  at_rail, report_ok;
   logic                  is_high, is_low, is_far_high, is_far_low;
   logic [POWER_WIDTH+1:0] thr_high_x4;

   assign thr_high_x4 = {thr_high, 2'b00};
   assign is_high     = avg_power_in > thr_high;
   assign is_low      = avg_power_in < thr_low;
   assign is_far_high = {2'b00, avg_power_in} > thr_high_x4;
   assign is_far_low  = avg_power_in < (thr_low >> 2);
   assign report_ok   = avg_power_valid_in && !cfg_q;
   assign step        = adj_coarse ? GAIN_WIDTH'(COARSE_STEP) : GAIN_WIDTH'(1);

   agc_gain_stepper #(
      .GAIN_WIDTH (GAIN_WIDTH),
      .GAIN_MIN   (GAIN_MIN),
      .GAIN_MAX   (GAIN_MAX)
   ) u_stepper (
      .gain      (gain),
      .step      (step),
      .up        (adj_up),
      .gain_next (gain_stepped),
      .at_rail   (at_rail)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         gain       <= GAIN_WIDTH'(GAIN_INIT);
         timer      <= '0;
         win_cnt    <= '0;
         locked_q   <= 1'b0;
         sat_q      <= 1'b0;
         upd_q      <= 1'b0;
         cfg_q      <= 1'b0;
         adj_up     <= 1'b0;
         adj_coarse <= 1'b0;
      end else begin
         state      <= state_nxt;
         gain       <= gain_nxt;
         timer      <= timer_nxt;
         win_cnt    <= win_cnt_nxt;
         locked_q   <= locked_nxt;
         sat_q      <= sat_nxt;
         upd_q      <= upd_nxt;
         cfg_q      <= (thr_low >= thr_high);
         adj_up     <= adj_up_nxt;
         adj_coarse <= adj_coarse_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      gain_nxt       = gain;
      timer_nxt      = timer;
      win_cnt_nxt    = win_cnt;
      locked_nxt     = locked_q;
      sat_nxt        = sat_q;
      upd_nxt        = 1'b0;
      adj_up_nxt     = adj_up;
      adj_coarse_nxt = adj_coarse;

      if (!enable) begin
         state_nxt   = IDLE;
         locked_nxt  = 1'b0;
         timer_nxt   = '0;
         win_cnt_nxt = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_nxt = SETTLE;
               timer_nxt = SETTLE_LOAD;
            end
            MEASURE, LOCKED: begin
               if (report_ok) begin
                  if (is_high || is_low) begin
                     state_nxt      = ADJUST;
                     win_cnt_nxt    = '0;
                     locked_nxt     = 1'b0;
                     adj_up_nxt     = !is_high;
                     adj_coarse_nxt = is_high ? is_far_high : is_far_low;
                  end else if (state == MEASURE) begin
                     win_cnt_nxt = win_cnt + 1'b1;
                     if (win_cnt == LOCK_LAST) begin
                        state_nxt  = LOCKED;
                        locked_nxt = 1'b1;
                     end
                  end
               end
            end
            ADJUST: begin
               if (!at_rail) begin
                  gain_nxt  = gain_stepped;
                  upd_nxt   = 1'b1;
                  sat_nxt   = 1'b0;
                  state_nxt = SETTLE;
                  timer_nxt = SETTLE_LOAD;
               end else begin
                  sat_nxt   = 1'b1;
                  state_nxt = MEASURE;
               end
            end
            SETTLE: begin
               if (timer == '0) state_nxt = FLUSH;
               else             timer_nxt = timer - 1'b1;
            end
            FLUSH: begin
               if (avg_power_valid_in) state_nxt = MEASURE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign gain_out       = gain;
   assign gain_update    = upd_q;
   assign locked         = locked_q;
   assign gain_saturated = sat_q;
   assign cfg_err        = cfg_q;
   assign state_out      = state;

endmodule
